// File: rtl/code_lock_ctrl.sv
// Multi-digit combination lock sequencer built around a W-bit XOR-reduce equality check.
// Holds a programmable secret, counts consecutive failures and enforces a timed lockout.
module code_lock_ctrl #(
   parameter int W           = 5,
   parameter int DIGITS      = 3,
   parameter int MAX_FAILS   = 3,
   parameter int LOCK_CYCLES = 1000,
   localparam int IW = ($clog2(DIGITS) > 1) ? $clog2(DIGITS) : 1,
   localparam int FW = $clog2(MAX_FAILS + 1)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_digit_valid,
   input  logic [W-1:0]  i_digit,
   input  logic          i_clr,
   input  logic          i_lock,
   input  logic          i_prog_we,
   input  logic [IW-1:0] i_prog_idx,
   input  logic [W-1:0]  i_prog_data,
   output logic          o_unlocked,
   output logic          o_err,
   output logic          o_lockout,
   output logic [IW-1:0] o_digit_cnt,
   output logic [FW-1:0] o_fail_cnt
);

   localparam int TW = ($clog2(LOCK_CYCLES) > 1) ? $clog2(LOCK_CYCLES) : 1;

   localparam logic [1:0] ST_ENTER   = 2'd0;
   localparam logic [1:0] ST_OPEN    = 2'd1;
   localparam logic [1:0] ST_LOCKOUT = 2'd2;

   localparam logic [IW-1:0] LAST_IDX   = IW'(DIGITS - 1);
   localparam logic [FW-1:0] FAIL_LIMIT = FW'(MAX_FAILS);
   localparam logic [TW-1:0] TIMER_LOAD = TW'(LOCK_CYCLES - 1);

   logic [1:0]    r_state;
   logic [W-1:0]  r_secret [DIGITS];
   logic [IW-1:0] r_digit_cnt;
   logic          r_mis;
   logic [FW-1:0] r_fail_cnt;
   logic [TW-1:0] r_timer;
   logic          r_err;

   logic          w_mis_next;
   logic          w_last;
   logic          w_idx_ok;
   logic [FW-1:0] w_fail_inc;

   // Mismatch accumulates across digits so a wrong combination is only revealed at the end.
   assign w_mis_next = r_mis | (|(i_digit ^ r_secret[r_digit_cnt]));
   assign w_last     = (r_digit_cnt == LAST_IDX);
   assign w_idx_ok   = (32'(i_prog_idx) < 32'(DIGITS));
   assign w_fail_inc = r_fail_cnt + FW'(1);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= ST_ENTER;
         r_digit_cnt <= '0;
         r_mis       <= 1'b0;
         r_fail_cnt  <= '0;
         r_timer     <= '0;
         r_err       <= 1'b0;
         for (int unsigned i = 0; i < DIGITS; i++) begin
            r_secret[i] <= '0;
         end
      end else begin
         r_err <= 1'b0;
         case (r_state)
            ST_ENTER: begin
               if (i_clr) begin
                  r_digit_cnt <= '0;
                  r_mis       <= 1'b0;
               end else if (i_digit_valid) begin
                  if (!w_last) begin
                     r_digit_cnt <= r_digit_cnt + IW'(1);
                     r_mis       <= w_mis_next;
                  end else begin
                     r_digit_cnt <= '0;
                     r_mis       <= 1'b0;
                     if (!w_mis_next) begin
                        r_state    <= ST_OPEN;
                        r_fail_cnt <= '0;
                     end else begin
                        r_err      <= 1'b1;
                        r_fail_cnt <= w_fail_inc;
                        if (w_fail_inc == FAIL_LIMIT) begin
                           r_state <= ST_LOCKOUT;
                           r_timer <= TIMER_LOAD;
                        end
                     end
                  end
               end
            end
            ST_OPEN: begin
               if (i_prog_we && w_idx_ok) begin
                  r_secret[i_prog_idx] <= i_prog_data;
               end
               if (i_lock) begin
                  r_state <= ST_ENTER;
               end
            end
            ST_LOCKOUT: begin
               if (r_timer == '0) begin
                  r_state    <= ST_ENTER;
                  r_fail_cnt <= '0;
               end else begin
                  r_timer <= r_timer - TW'(1);
               end
            end
            default: r_state <= ST_ENTER;
         endcase
      end
   end

   assign o_unlocked  = (r_state == ST_OPEN);
   assign o_lockout   = (r_state == ST_LOCKOUT);
   assign o_err       = r_err;
   assign o_digit_cnt = r_digit_cnt;
   assign o_fail_cnt  = r_fail_cnt;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Directed bench for code_lock_ctrl: vector table for single-cycle behaviour,
// hand sequences for lockout timing and reset in mid-entry / mid-lockout.
module tb_code_lock_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       dv = 1'b0;
   logic [4:0] digit = '0;
   logic       clr = 1'b0;
   logic       lk = 1'b0;
   logic       pwe = 1'b0;
   logic [1:0] pidx = '0;
   logic [4:0] pdata = '0;
   logic       unl, err, lo;
   logic [1:0] cnt, fcnt;

   int n_cmp = 0;
   int n_bad = 0;

   code_lock_ctrl #(.W(5), .DIGITS(3), .MAX_FAILS(3), .LOCK_CYCLES(8)) dut (
      .i_clk(clk), .i_rst(rst), .i_digit_valid(dv), .i_digit(digit), .i_clr(clr),
      .i_lock(lk), .i_prog_we(pwe), .i_prog_idx(pidx), .i_prog_data(pdata),
      .o_unlocked(unl), .o_err(err), .o_lockout(lo), .o_digit_cnt(cnt), .o_fail_cnt(fcnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst, dv;
      logic [4:0] digit;
      logic       clr, lk, pwe;
      logic [1:0] pidx;
      logic [4:0] pdata;
      logic       e_unl, e_err, e_lo;
      logic [1:0] e_cnt, e_fail;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic v, input logic [4:0] d, input logic c,
                      input logic l, input logic w, input logic [1:0] pi, input logic [4:0] pd,
                      input logic eu, input logic ee, input logic el,
                      input logic [1:0] ec, input logic [1:0] ef);
      vecs.push_back('{r, v, d, c, l, w, pi, pd, eu, ee, el, ec, ef});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string nm, input logic eu, input logic ee, input logic el,
                          input logic [1:0] ec, input logic [1:0] ef);
      chk({nm, ".unlocked"}, 32'(unl), 32'(eu));
      chk({nm, ".err"}, 32'(err), 32'(ee));
      chk({nm, ".lockout"}, 32'(lo), 32'(el));
      chk({nm, ".digit_cnt"}, 32'(cnt), 32'(ec));
      chk({nm, ".fail_cnt"}, 32'(fcnt), 32'(ef));
   endtask

   task automatic idle();
      dv = 0; clr = 0; lk = 0; pwe = 0; rst = 0;
   endtask

   task automatic enter3(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
      dv = 1; digit = a; tick();
      digit = b; tick();
      digit = c; tick();
      dv = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   logic [4:0] good [3];
   int n;

   initial begin
      good[0] = 5'd5; good[1] = 5'd17; good[2] = 5'd31;
      //   rst dv dig clr lk pwe idx data | unl err lo cnt fail
      add(1, 0,  0, 0, 0, 0, 0,  0,  0, 0, 0, 0, 0);
      add(0, 1,  0, 0, 0, 0, 0,  0,  0, 0, 0, 1, 0);
      add(0, 1,  0, 0, 0, 0, 0,  0,  0, 0, 0, 2, 0);
      add(0, 1,  0, 0, 0, 0, 0,  0,  1, 0, 0, 0, 0);
      add(0, 0,  0, 0, 0, 1, 0,  5,  1, 0, 0, 0, 0);
      add(0, 0,  0, 0, 0, 1, 1, 17,  1, 0, 0, 0, 0);
      add(0, 0,  0, 0, 0, 1, 2, 31,  1, 0, 0, 0, 0);
      add(0, 0,  0, 0, 0, 1, 3,  1,  1, 0, 0, 0, 0);
      add(0, 1,  0, 0, 0, 0, 0,  0,  1, 0, 0, 0, 0);
      add(0, 0,  0, 0, 1, 0, 0,  0,  0, 0, 0, 0, 0);
      add(0, 1,  5, 0, 0, 0, 0,  0,  0, 0, 0, 1, 0);
      add(0, 1, 17, 0, 0, 0, 0,  0,  0, 0, 0, 2, 0);
      add(0, 1, 30, 0, 0, 0, 0,  0,  0, 1, 0, 0, 1);
      add(0, 0,  0, 0, 0, 0, 0,  0,  0, 0, 0, 0, 1);
      add(0, 1,  5, 0, 0, 0, 0,  0,  0, 0, 0, 1, 1);
      add(0, 1, 17, 0, 0, 0, 0,  0,  0, 0, 0, 2, 1);
      add(0, 1, 31, 0, 0, 0, 0,  0,  1, 0, 0, 0, 0);
      add(0, 0,  0, 0, 1, 0, 0,  0,  0, 0, 0, 0, 0);
      add(0, 1,  1, 0, 0, 0, 0,  0,  0, 0, 0, 1, 0);
      add(0, 1,  1, 0, 0, 0, 0,  0,  0, 0, 0, 2, 0);
      add(0, 1,  1, 0, 0, 0, 0,  0,  0, 1, 0, 0, 1);
      add(0, 1,  5, 0, 0, 0, 0,  0,  0, 0, 0, 1, 1);
      add(0, 1, 17, 0, 0, 0, 0,  0,  0, 0, 0, 2, 1);
      add(0, 1, 31, 1, 0, 0, 0,  0,  0, 0, 0, 0, 1);
      add(0, 0,  0, 0, 0, 0, 0,  0,  0, 0, 0, 0, 1);
      add(0, 1,  5, 0, 0, 0, 0,  0,  0, 0, 0, 1, 1);
      add(0, 1, 17, 0, 0, 0, 0,  0,  0, 0, 0, 2, 1);
      add(0, 1, 31, 0, 0, 0, 0,  0,  1, 0, 0, 0, 0);
      add(0, 0,  0, 0, 1, 1, 2,  7,  0, 0, 0, 0, 0);
      add(0, 1,  5, 0, 0, 0, 0,  0,  0, 0, 0, 1, 0);
      add(0, 1, 17, 0, 0, 0, 0,  0,  0, 0, 0, 2, 0);
      add(0, 1,  7, 0, 0, 0, 0,  0,  1, 0, 0, 0, 0);
      add(0, 0,  0, 0, 0, 1, 2, 31,  1, 0, 0, 0, 0);
      add(0, 0,  0, 0, 1, 0, 0,  0,  0, 0, 0, 0, 0);
      add(0, 0,  0, 0, 0, 1, 0,  9,  0, 0, 0, 0, 0);
      add(0, 1,  5, 0, 0, 0, 0,  0,  0, 0, 0, 1, 0);
      add(0, 1, 17, 0, 0, 0, 0,  0,  0, 0, 0, 2, 0);
      add(0, 1, 31, 0, 0, 0, 0,  0,  1, 0, 0, 0, 0);
      add(0, 0,  0, 0, 1, 0, 0,  0,  0, 0, 0, 0, 0);
      add(0, 1,  1, 0, 0, 0, 0,  0,  0, 0, 0, 1, 0);
      add(0, 0,  0, 1, 0, 0, 0,  0,  0, 0, 0, 0, 0);
      add(0, 1,  5, 0, 0, 0, 0,  0,  0, 0, 0, 1, 0);
      add(0, 1, 17, 0, 0, 0, 0,  0,  0, 0, 0, 2, 0);
      add(0, 1, 31, 0, 0, 0, 0,  0,  1, 0, 0, 0, 0);
      add(0, 0,  0, 0, 1, 0, 0,  0,  0, 0, 0, 0, 0);
      add(0, 1,  5, 0, 0, 0, 0,  0,  0, 0, 0, 1, 0);
      add(0, 1, 17, 0, 0, 0, 0,  0,  0, 0, 0, 2, 0);
      add(0, 1, 31, 0, 0, 0, 0,  0,  1, 0, 0, 0, 0);
      add(0, 0,  0, 0, 1, 0, 0,  0,  0, 0, 0, 0, 0);

      #2;
      foreach (vecs[i]) begin
         rst = vecs[i].rst; dv = vecs[i].dv; digit = vecs[i].digit; clr = vecs[i].clr;
         lk = vecs[i].lk; pwe = vecs[i].pwe; pidx = vecs[i].pidx; pdata = vecs[i].pdata;
         tick();
         chk_all($sformatf("vec%0d", i), vecs[i].e_unl, vecs[i].e_err, vecs[i].e_lo,
                 vecs[i].e_cnt, vecs[i].e_fail);
      end
      idle();

      // Three wrong combinations back-to-back, then time the lockout window.
      enter3(1, 1, 1); chk_all("lk1", 0, 1, 0, 0, 1);
      enter3(1, 1, 1); chk_all("lk2", 0, 1, 0, 0, 2);
      enter3(1, 1, 1); chk_all("lk3", 0, 1, 1, 0, 3);
      n = 0;
      while (lo === 1'b1 && n < 20) begin
         n++;
         chk($sformatf("lo%0d.digit_cnt", n), 32'(cnt), 0);
         chk($sformatf("lo%0d.err", n), 32'(err), (n == 1) ? 32'd1 : 32'd0);
         chk($sformatf("lo%0d.fail_cnt", n), 32'(fcnt), 3);
         dv = 1; digit = good[n % 3]; lk = 1; pwe = 1; pidx = 0; pdata = 5'd0;
         tick();
      end
      idle();
      chk("lockout_len", 32'(n), 8);
      chk_all("post_lo", 0, 0, 0, 0, 0);
      enter3(5, 17, 31); chk_all("post_lo_open", 1, 0, 0, 0, 0);

      // Reset during lockout restores the all-zero secret.
      lk = 1; tick(); idle();
      enter3(1, 1, 1); enter3(1, 1, 1); enter3(1, 1, 1);
      tick(); tick();
      chk_all("mid_lo", 0, 0, 1, 0, 3);
      rst = 1; tick(); idle();
      chk_all("rst_lo", 0, 0, 0, 0, 0);
      enter3(0, 0, 0); chk_all("rst_lo_open", 1, 0, 0, 0, 0);

      // Reset during a partial entry.
      pwe = 1; pidx = 0; pdata = 5'd5; tick(); idle();
      lk = 1; tick(); idle();
      enter3(1, 1, 1); chk_all("pre_rst_fail", 0, 1, 0, 0, 1);
      dv = 1; digit = 5'd5; tick();
      chk_all("mid_entry", 0, 0, 0, 1, 1);
      rst = 1; digit = 5'd0; tick(); idle();
      chk_all("rst_entry", 0, 0, 0, 0, 0);
      enter3(0, 0, 0); chk_all("rst_entry_open", 1, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/code_lock_ctrl.md
# code_lock_ctrl

Sequencing controller for the 5-bit equality comparator datapath. It turns the single-shot "A equals B" check into a multi-digit combination lock. It holds a programmable secret of DIGITS words and compares each entered word against the matching secret word using XOR-reduce equality. It reports open, error and lockout status, and enforces a failed-attempt limit with a timed lockout. It sits between debounced switch/strobe inputs and LED indicators.

## Interface
- W, 5: width of one code digit (comparator width).
- DIGITS, 3: number of digits per combination, ≥2.
- MAX_FAILS, 3: consecutive wrong combinations that trigger lockout, ≥1.
- LOCK_CYCLES, 1000: lockout duration in clock cycles, ≥1.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- digit_valid  in  1  one-cycle strobe; digit is presented this cycle.
- digit  in  W  entered code digit.
- clr  in  1  abort the current partial entry.
- lock  in  1  re-lock request, honoured only while open.
- prog_we  in  1  secret write strobe, honoured only while open.
- prog_idx  in  IW  secret digit index, IW = max(1, $clog2(DIGITS)).
- prog_data  in  W  secret digit value.
- unlocked  out  1  high while in OPEN.
- err  out  1  one-cycle pulse per wrong combination.
- lockout  out  1  high while in LOCKOUT.
- digit_cnt  out  IW  digits accepted in the current entry.
- fail_cnt  out  FW  consecutive failures, FW = $clog2(MAX_FAILS+1).

## Operation
- States: ENTER, OPEN, LOCKOUT. Reset values: state ENTER, all secret digits 0, digit_cnt 0, mismatch flag 0, fail_cnt 0, timer 0, all outputs 0.
- Outputs are registered. unlocked = (state==OPEN); lockout = (state==LOCKOUT).
- ENTER, digit_valid=1:
  - mismatch |= |(digit ^ secret[digit_cnt]). The flag is sticky and never exposed early.
  - If digit_cnt < DIGITS-1: digit_cnt increments.
  - Otherwise the combination is complete: digit_cnt and mismatch clear.
    - If the final mismatch value is 0: go to OPEN and clear fail_cnt.
    - Otherwise: pulse err and increment fail_cnt. If the new fail_cnt equals MAX_FAILS, go to LOCKOUT and load timer = LOCK_CYCLES-1. Otherwise stay in ENTER.
- ENTER, clr=1: clear digit_cnt and mismatch. No failure is counted. clr beats a simultaneous digit_valid, and that digit is discarded.
- OPEN:
  - digit_valid and clr are ignored.
  - prog_we writes secret[prog_idx] = prog_data. prog_idx ≥ DIGITS is ignored.
  - lock=1 returns to ENTER. If prog_we and lock occur in the same cycle, the write takes effect and the lock is honoured.
- LOCKOUT:
  - digit_valid, clr, lock and prog_we are ignored.
  - The timer decrements each cycle. In the cycle it is 0: go to ENTER and clear fail_cnt.
- prog_we is ignored in ENTER and LOCKOUT.
- A rst asserted in any state, including mid-entry or mid-lockout, returns everything to reset values, including the secret.

## Timing
- Final digit strobed in cycle t: unlocked, err or lockout is visible at t+1. err is high for exactly cycle t+1.
- Intermediate digits: digit_cnt updates at t+1.
- lock in cycle t: unlocked low at t+1. A digit strobed at t+1 is accepted as the first digit.
- Lockout entered at t+1: lockout is high for exactly LOCK_CYCLES cycles, then low with fail_cnt=0.
- prog write at t: the new value is used by comparisons from t+1.
- Back-to-back digit_valid on consecutive cycles is supported with no stall.

## Test plan
- Reset, then digits 0,0,0 on consecutive cycles -> unlocked=1 one cycle after the third digit; fail_cnt=0; err never pulses.
- While OPEN, program secret {5,17,31}, then lock. Enter 5,17,30 -> err one-cycle pulse, fail_cnt=1, unlocked stays 0. Then enter 5,17,31 -> unlocked=1, fail_cnt=0.
- LOCK_CYCLES=8, secret {5,17,31}: three wrong combinations -> lockout high for exactly 8 cycles. Correct digits strobed during lockout are ignored (digit_cnt stays 0). After lockout, fail_cnt=0 and the correct code opens.
- Enter 5,17, then clr in the same cycle as digit 31 -> digit_cnt=0, no err, fail_cnt unchanged. Then 5,17,31 -> unlocked.
- prog_we in ENTER with idx 0, data 9 -> ignored; secret 5,17,31 still opens. In OPEN, prog_we and lock in the same cycle -> write applied and state is ENTER.
- rst mid-lockout and mid-entry -> all outputs 0 next cycle, secret back to 0,0,0 (opens with 0,0,0).
